trace_capture_buffer: RTL

Parametrised, synthesizable trace buffer that records per-cycle processor observation signals (PC, instruction, ALU result, register write data, ...) into a circular store. Capture is armed by software or a bench, stops on a PC-match trigger plus a programmable post-trigger window or when the store fills, and is drained oldest-first over a valid/ready port. It replaces ad-hoc waveform probing of the top-level datapath and sits beside `top`, fed by its debug outputs.

---
 rtl/trace_pkg.sv | 17 +
 rtl/trace_mem.sv | 24 ++
 rtl/trace_capture_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture buffer: FSM state encoding and
// channel indices of the observation sample.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CH_PC    = 0;
  localparam int CH_INSTR = 1;
  localparam int CH_ALU   = 2;
  localparam int CH_WB    = 3;

endpackage

// File: rtl/trace_mem.sv
// Sample storage: register file with one synchronous write port and one
// asynchronous read port. Storage is deliberately left without reset.
module trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular trace buffer: arms on request, stops on PC trigger plus a post
// window (or on full), then drains oldest-first over a valid/ready port.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_CH*DATA_W-1:0] ChIn,
  input  logic                     SampleValid,
  input  logic                     Arm,
  input  logic                     StopOnFull,
  input  logic                     TrigEn,
  input  logic [DATA_W-1:0]        TrigPC,
  input  logic [CNT_W-1:0]         PostCount,
  output logic [1:0]               State,
  output logic                     Triggered,
  output logic                     Done,
  output logic [CNT_W-1:0]         Count,
  output logic                     Overflow,
  output logic                     RdValid,
  input  logic                     RdReady,
  output logic [NUM_CH*DATA_W-1:0] RdData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);

  state_t                    state;
  logic [PTR_W-1:0]          wrPtr;
  logic [PTR_W-1:0]          rdPtr;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          postLeft;
  logic [CNT_W-1:0]          postLatched;
  logic [CNT_W-1:0]          postClamped;
  logic                      stopLatched;
  logic                      triggered;
  logic                      overflow;
  logic                      wrEn;
  logic                      trigHit;
  logic                      pop;
  logic [NUM_CH*DATA_W-1:0]  memData;

  assign wrEn        = SampleValid && !Arm && (state == ST_ARMED || state == ST_POST);
  assign trigHit     = TrigEn && SampleValid && (ChIn[CH_PC*DATA_W +: DATA_W] == TrigPC);
  assign pop         = RdValid && RdReady;
  assign postClamped = (PostCount > MAX_POST) ? MAX_POST : PostCount;

  // Oldest entry sits Count slots behind the write pointer; a full store wraps to WrPtr.
  assign rdPtr = wrPtr - count[PTR_W-1:0];

  trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (NUM_CH*DATA_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .Clk   (Clk),
    .we    (wrEn),
    .waddr (wrPtr),
    .wdata (ChIn),
    .raddr (rdPtr),
    .rdata (memData)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      wrPtr       <= '0;
      count       <= '0;
      postLeft    <= '0;
      postLatched <= '0;
      stopLatched <= 1'b0;
      triggered   <= 1'b0;
      overflow    <= 1'b0;
    end else if (Arm) begin
      state       <= ST_ARMED;
      wrPtr       <= '0;
      count       <= '0;
      postLeft    <= '0;
      postLatched <= postClamped;
      stopLatched <= StopOnFull;
      triggered   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + PTR_W'(1);
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + CNT_W'(1);
      end
      if (pop) count <= count - CNT_W'(1);

      case (state)
        ST_ARMED: begin
          if (stopLatched) begin
            if (wrEn && count == FULL - CNT_W'(1)) state <= ST_DONE;
          end else if (trigHit) begin
            triggered <= 1'b1;
            postLeft  <= postLatched;
            state     <= (postLatched == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (wrEn) begin
            postLeft <= postLeft - CNT_W'(1);
            if (postLeft == CNT_W'(1)) state <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign State     = state;
  assign Triggered = triggered;
  assign Done      = (state == ST_DONE);
  assign Count     = count;
  assign Overflow  = overflow;
  assign RdValid   = (state == ST_DONE) && (count != '0);
  assign RdData    = RdValid ? memData : '0;

endmodule
